// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, start/data/parity/stop sampling,
// single-entry output register with valid/ready handshake and error pulses.
module uart_rx #(
  parameter int unsigned DW       = 8,
  parameter int unsigned SW       = 1,
  parameter logic        IDLE     = 1'b1,
  parameter string       PARITY   = "NONE",
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rxd,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          err_parity,
  output logic          err_frame,
  output logic          err_overrun,
  output logic          busy
);

  localparam int unsigned CW  = $clog2(BAUD_DIV);
  localparam int unsigned IW  = $clog2(DW);
  localparam int unsigned SWW = $clog2(SW + 1);
  localparam logic [CW-1:0]  HALF      = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL      = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(DW - 1);
  localparam logic [SWW-1:0] LAST_STOP = SWW'(SW - 1);
  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic           sync1, line, prev;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  idx;
  logic [SWW-1:0] sidx;
  logic [DW-1:0]  shift;
  logic           par_bad, frm_bad;
  logic           start_edge, half_tick, bit_tick, par_exp, load;

  assign start_edge = (prev == IDLE) && (line != IDLE);
  assign half_tick  = (cnt == HALF);
  assign bit_tick   = (cnt == FULL);
  assign par_exp    = PAR_ODD ? ~^shift : ^shift;
  assign load       = !rx_valid || rx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= IDLE;
      line  <= IDLE;
      prev  <= IDLE;
    end else begin
      sync1 <= rxd;
      line  <= sync1;
      prev  <= line;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    err_parity  = 1'b0;
    err_frame   = 1'b0;
    err_overrun = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE:   if (start_edge) state_n = S_START;
      S_START:  if (half_tick) state_n = (line == IDLE) ? S_IDLE : S_DATA;
      S_DATA:   if (bit_tick && idx == LAST_IDX) state_n = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_n = S_STOP;
      S_STOP:   if (bit_tick && sidx == LAST_STOP) state_n = S_DONE;
      S_DONE: begin
        state_n     = S_IDLE;
        err_parity  = par_bad;
        err_frame   = frm_bad;
        err_overrun = !load;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      sidx     <= '0;
      shift    <= '0;
      par_bad  <= 1'b0;
      frm_bad  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      // cnt restarts at the mid start bit so every later tick lands mid-bit
      if (state == S_IDLE || bit_tick || (state == S_START && half_tick))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      case (state)
        S_START: if (half_tick) begin
          idx     <= '0;
          sidx    <= '0;
          par_bad <= 1'b0;
          frm_bad <= 1'b0;
        end
        S_DATA: if (bit_tick) begin
          shift[idx] <= line;
          idx        <= idx + IW'(1);
        end
        S_PARITY: if (bit_tick) par_bad <= (line != par_exp);
        S_STOP: if (bit_tick) begin
          sidx <= sidx + SWW'(1);
          if (line != IDLE) frm_bad <= 1'b1;
        end
        default: ;
      endcase

      if (state == S_DONE && load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: instance a uses no parity, instance b even parity.
module tb_uart_rx;

  localparam int BD = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rxd_a, rxd_b, ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       perr_a, ferr_a, oerr_a, busy_a;
  logic       perr_b, ferr_b, oerr_b, busy_b;

  int tests = 0;
  int fails = 0;

  // event counters sampled on the falling edge
  int hs_a = 0, vcyc_a = 0, pe_a = 0, fe_a = 0, oe_a = 0;
  int hs_b = 0, pe_b = 0, fe_b = 0, oe_b = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;
  int s_hs_a, s_vcyc_a, s_pe_a, s_fe_a, s_oe_a, s_hs_b, s_pe_b, s_fe_b, s_oe_b;

  always #5 clock = ~clock;

  uart_rx #(.BAUD_DIV(BD)) u_a (
    .clock(clock), .reset(reset), .rxd(rxd_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .err_parity(perr_a), .err_frame(ferr_a), .err_overrun(oerr_a), .busy(busy_a)
  );

  uart_rx #(.PARITY("EVEN"), .BAUD_DIV(BD)) u_b (
    .clock(clock), .reset(reset), .rxd(rxd_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .err_parity(perr_b), .err_frame(ferr_b), .err_overrun(oerr_b), .busy(busy_b)
  );

  always @(negedge clock) begin
    if (valid_a) vcyc_a++;
    if (valid_a && ready_a) begin hs_a++; last_a = data_a; end
    if (perr_a) pe_a++;
    if (ferr_a) fe_a++;
    if (oerr_a) oe_a++;
    if (valid_b && ready_b) begin hs_b++; last_b = data_b; end
    if (perr_b) pe_b++;
    if (ferr_b) fe_b++;
    if (oerr_b) oe_b++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                      input logic par_bit, input logic stop_bit);
    set_line(sel, 1'b0);
    step(BD);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      step(BD);
    end
    if (par_en) begin
      set_line(sel, par_bit);
      step(BD);
    end
    set_line(sel, stop_bit);
    step(BD);
    set_line(sel, 1'b1);
    step(20);
  endtask

  task automatic snap();
    s_hs_a = hs_a; s_vcyc_a = vcyc_a; s_pe_a = pe_a; s_fe_a = fe_a; s_oe_a = oe_a;
    s_hs_b = hs_b; s_pe_b = pe_b; s_fe_b = fe_b; s_oe_b = oe_b;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    step(3);
    chk("reset_data", 32'(data_a), 32'h00);
    chk("reset_valid", 32'(valid_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    chk("reset_errs", 32'({perr_a, ferr_a, oerr_a}), 32'h0);
    reset = 1'b0;
    step(5);

    // T1: plain character, consumer always ready
    snap();
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("t1_hs", 32'(hs_a - s_hs_a), 32'd1);
    chk("t1_data", 32'(last_a), 32'hA5);
    chk("t1_vcyc", 32'(vcyc_a - s_vcyc_a), 32'd1);
    chk("t1_errs", 32'((pe_a - s_pe_a) + (fe_a - s_fe_a) + (oe_a - s_oe_a)), 32'd0);
    chk("t1_busy", 32'(busy_a), 32'h0);

    // T2: even parity, 8'h07 has three ones so the parity bit is 1
    snap();
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("t2_good_hs", 32'(hs_b - s_hs_b), 32'd1);
    chk("t2_good_data", 32'(last_b), 32'h07);
    chk("t2_good_perr", 32'(pe_b - s_pe_b), 32'd0);
    snap();
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("t2_bad_hs", 32'(hs_b - s_hs_b), 32'd1);
    chk("t2_bad_data", 32'(last_b), 32'h07);
    chk("t2_bad_perr", 32'(pe_b - s_pe_b), 32'd1);
    chk("t2_bad_ferr", 32'(fe_b - s_fe_b), 32'd0);

    // T3: stop bit held low
    snap();
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t3_hs", 32'(hs_a - s_hs_a), 32'd1);
    chk("t3_data", 32'(last_a), 32'h3C);
    chk("t3_ferr", 32'(fe_a - s_fe_a), 32'd1);
    chk("t3_perr", 32'(pe_a - s_pe_a), 32'd0);

    // T4: consumer stalled, second character overruns
    ready_a = 1'b0;
    snap();
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("t4_valid", 32'(valid_a), 32'h1);
    chk("t4_data", 32'(data_a), 32'h11);
    chk("t4_oerr", 32'(oe_a - s_oe_a), 32'd1);
    chk("t4_no_hs", 32'(hs_a - s_hs_a), 32'd0);
    ready_a = 1'b1;
    step(1);
    chk("t4_cleared", 32'(valid_a), 32'h0);
    chk("t4_hs", 32'(hs_a - s_hs_a), 32'd1);
    chk("t4_hs_data", 32'(last_a), 32'h11);

    // T5: short glitch is a false start
    snap();
    rxd_a = 1'b0;
    step(BD / 4);
    rxd_a = 1'b1;
    step(40);
    chk("t5_busy", 32'(busy_a), 32'h0);
    chk("t5_hs", 32'(hs_a - s_hs_a), 32'd0);
    chk("t5_errs", 32'((pe_a - s_pe_a) + (fe_a - s_fe_a) + (oe_a - s_oe_a)), 32'd0);
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("t5_next_hs", 32'(hs_a - s_hs_a), 32'd1);
    chk("t5_next_data", 32'(last_a), 32'h5A);

    // T6: reset pulse in the middle of 8'hFF
    snap();
    rxd_a = 1'b0;
    step(BD);
    rxd_a = 1'b1;
    step(40);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(130);
    chk("t6_abort_hs", 32'(hs_a - s_hs_a), 32'd0);
    chk("t6_abort_errs", 32'((fe_a - s_fe_a) + (oe_a - s_oe_a)), 32'd0);
    chk("t6_abort_busy", 32'(busy_a), 32'h0);
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    chk("t6_hs", 32'(hs_a - s_hs_a), 32'd1);
    chk("t6_data", 32'(last_a), 32'h81);
    chk("t6_vcyc", 32'(vcyc_a - s_vcyc_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
